// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
//   instruction_t  : 32-bit instruction word passed from IF to ID
//   fetch_state_t  : IF request/response sequencer states
//   NOP_INSTR      : bubble word (addi x0,x0,0), also used by decode/hazard logic
//   PC_STEP        : sequential fetch increment
//   align_word()   : clears the byte-offset bits of an address
package instruction_fetch_stage_pkg;

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam instruction_t NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0]  PC_STEP   = 32'd4;

  // Instruction fetch is word addressed; bits [1:0] are always forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus: valid/ready request channel plus a valid-only
// response channel (exactly one response per accepted request).
//   req_valid  : request valid            (master -> slave)
//   req_addr   : request word address     (master -> slave)
//   req_ready  : slave accepts request    (slave -> master)
//   resp_valid : response data valid      (slave -> master)
//   resp_data  : fetched word             (slave -> master)
interface instruction_fetch_stage_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/instruction_fetch_stage_chk.sv
// Bus protocol checker for the instruction-memory interface (simulation only).
//   clk, rst      : clock and fetch-stage reset
//   req_valid     : request valid
//   req_ready     : request accepted
//   resp_valid    : response valid
//   req_addr_lsb  : low two bits of the request address
// A response is legal only while a request is outstanding. The outstanding
// flag deliberately ignores rst: memory still answers a request accepted just
// before a fetch-stage reset, and that late response must not be flagged.
module instruction_fetch_stage_chk (
  input logic       clk,
  input logic       rst,
  input logic       req_valid,
  input logic       req_ready,
  input logic       resp_valid,
  input logic [1:0] req_addr_lsb
);

  logic pending_r;

  // Track whether memory owes a response (set on handshake, cleared on response).
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      pending_r <= 1'b1;
    end else if (resp_valid) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  a_resp_has_req: assert property (@(posedge clk) resp_valid |-> pending_r)
    else $error("instruction_fetch_stage_chk: response without outstanding request");

  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> (req_addr_lsb == 2'b00))
    else $error("instruction_fetch_stage_chk: unaligned fetch address");

endmodule

// File: rtl/instruction_fetch_stage_fetch_pc_gen.sv
// Fetch PC register with its next-PC mux.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_PC)
//   advance   : step to the next sequential word (+4, modulo 2^32)
//   redirect  : load the word-aligned target (wins over advance)
//   target    : redirect address, low two bits ignored
//   fetch_pc  : current fetch address
module fetch_pc_gen
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] fetch_pc
);

  logic [31:0] fetch_pc_r;
  logic [31:0] next_pc_s;

  // Next-PC selection: redirect > sequential advance > hold.
  always_comb begin
    next_pc_s = fetch_pc_r;
    if (redirect) begin
      next_pc_s = align_word(target);
    end else if (advance) begin
      next_pc_s = fetch_pc_r + PC_STEP;
    end else begin
      next_pc_s = fetch_pc_r;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else begin
      fetch_pc_r <= next_pc_s;
    end
  end

  assign fetch_pc = fetch_pc_r;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF pipeline stage: owns the fetch PC, keeps one instruction-memory request
// in flight, and registers the fetched word and its PC into the IF/ID outputs.
//   clk, rst       : clock, asynchronous active-high reset
//   stall          : hold IF/ID outputs and fetch PC
//   flush          : squash IF/ID outputs to a bubble
//   branch_taken   : redirect fetch to branch_target (implies flush)
//   branch_target  : redirect address, bits [1:0] ignored
//   imem           : instruction-memory bus (master side)
//   instruction    : fetched word, NOP_INSTR when not valid
//   pc             : PC of instruction
//   instr_valid    : instruction/pc hold a real instruction
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instruction_fetch_stage_pkg::NOP_INSTR
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall,
  input  logic                                     flush,
  input  logic                                     branch_taken,
  input  logic [31:0]                              branch_target,
  instruction_fetch_stage_if.master                imem,
  output instruction_fetch_stage_pkg::instruction_t instruction,
  output logic [31:0]                              pc,
  output logic                                     instr_valid
);

  import instruction_fetch_stage_pkg::*;

  fetch_state_t state_r;
  instruction_t skid_data_r;
  instruction_t instruction_r;
  logic [31:0]  pc_r;
  logic         instr_valid_r;

  logic [31:0]  fetch_pc_s;
  logic         handshake_s;
  logic         resp_in_wait_s;
  logic         deliver_s;
  logic         advance_s;

  // Handshake and delivery qualifiers shared by the FSM and the PC generator.
  always_comb begin
    handshake_s    = (state_r == REQ) && imem.req_ready;
    resp_in_wait_s = (state_r == WAIT) && imem.resp_valid;
    deliver_s      = !stall && (resp_in_wait_s || (state_r == HOLD));
    // A flush alone still consumes the word (PC advances); only a redirect cancels it.
    advance_s      = deliver_s && !branch_taken;
  end

  assign imem.req_valid = (state_r == REQ);
  assign imem.req_addr  = fetch_pc_s;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_s),
    .redirect (branch_taken),
    .target   (branch_target),
    .fetch_pc (fetch_pc_s)
  );

  // Fetch sequencer, skid buffer and IF/ID output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= REQ;
      skid_data_r   <= NOP_INSTR;
      instruction_r <= NOP_INSTR;
      pc_r          <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          // A request accepted in the redirect cycle targets the old PC; its response is discarded.
          if (handshake_s) begin
            state_r <= branch_taken ? DISCARD : WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (imem.resp_valid) begin
            if (branch_taken) begin
              state_r <= REQ;
            end else if (stall) begin
              state_r     <= HOLD;
              skid_data_r <= imem.resp_data;
            end else begin
              state_r <= REQ;
            end
          end else begin
            state_r <= branch_taken ? DISCARD : WAIT;
          end
        end
        HOLD: begin
          if (branch_taken || !stall) begin
            state_r <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        DISCARD: begin
          state_r <= imem.resp_valid ? REQ : DISCARD;
        end
        default: begin
          state_r <= REQ;
        end
      endcase

      if (branch_taken || flush) begin
        instruction_r <= NOP_INSTR;
        instr_valid_r <= 1'b0;
      end else if (stall) begin
        instruction_r <= instruction_r;
        pc_r          <= pc_r;
        instr_valid_r <= instr_valid_r;
      end else if (resp_in_wait_s) begin
        instruction_r <= imem.resp_data;
        pc_r          <= fetch_pc_s;
        instr_valid_r <= 1'b1;
      end else if (state_r == HOLD) begin
        instruction_r <= skid_data_r;
        pc_r          <= fetch_pc_s;
        instr_valid_r <= 1'b1;
      end else begin
        instruction_r <= NOP_INSTR;
        instr_valid_r <= 1'b0;
      end
    end
  end

  assign instruction = instruction_r;
  assign pc          = pc_r;
  assign instr_valid = instr_valid_r;

  instruction_fetch_stage_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (imem.req_valid),
    .req_ready    (imem.req_ready),
    .resp_valid   (imem.resp_valid),
    .req_addr_lsb (imem.req_addr[1:0])
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. Two instances share clock,
// reset and pipeline controls: dut (RESET_PC 0, scripted memory) and dut2
// (RESET_PC 32'hFFFF_FFFC, always-ready memory) for the wrap-around case.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Memory answers one cycle after a handshake with word_of(addr).
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;
  logic [31:0] instruction2;
  logic [31:0] pc2;
  logic        instr_valid2;

  logic        mem_auto;
  logic        force_resp;
  logic [31:0] force_data;

  int total;
  int bad;

  instruction_fetch_stage_if bus ();
  instruction_fetch_stage_if bus2 ();

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .instruction   (instruction),
    .pc            (pc),
    .instr_valid   (instr_valid)
  );

  instruction_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus2),
    .instruction   (instruction2),
    .pc            (pc2),
    .instr_valid   (instr_valid2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always #5 clk = ~clk;

  // Memory for dut: scripted ready, 1-cycle response, optional forced response.
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    bus.resp_valid = 1'b0;
    bus.resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs      = bus.req_valid && bus.req_ready;
      hs_addr = bus.req_addr;
      @(posedge clk);
      #2;
      bus.resp_valid = (mem_auto && hs) || force_resp;
      bus.resp_data  = force_resp ? force_data : word_of(hs_addr);
    end
  end

  // Memory for dut2: always ready, 1-cycle response.
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    bus2.req_ready  = 1'b1;
    bus2.resp_valid = 1'b0;
    bus2.resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs      = bus2.req_valid && bus2.req_ready;
      hs_addr = bus2.req_addr;
      @(posedge clk);
      #2;
      bus2.resp_valid = hs;
      bus2.resp_data  = word_of(hs_addr);
    end
  end

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    bus.req_ready = 1'b0;
    mem_auto = 1'b1;
    force_resp = 1'b0;
    force_data = 32'h0;
    #1 rst = 1'b1;
    adv();
    adv();
    smp();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", 32'(bus.req_valid), 32'd1);
    chk("rst_req_addr", bus.req_addr, 32'h0);

    // 1: streaming with ready=1, k=1
    adv();                                   // C0
    rst = 1'b0;
    bus.req_ready = 1'b1;
    smp();
    chk("c0_req_addr", bus.req_addr, 32'h0);
    adv();                                   // C1
    smp();
    chk("c1_req_valid", 32'(bus.req_valid), 32'd0);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C2
    smp();
    chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_instr", instruction, word_of(32'h0));
    chk("c2_pc", pc, 32'h0);
    chk("c2_req_addr", bus.req_addr, 32'h4);
    adv();                                   // C3
    smp();
    chk("c3_valid", 32'(instr_valid), 32'd0);
    chk("c3_instr", instruction, NOP);

    // 3: stall over the addr-8 response
    adv();                                   // C4
    stall = 1'b1;
    smp();
    chk("c4_pc", pc, 32'h4);
    chk("c4_instr", instruction, word_of(32'h4));
    chk("c4_req_addr", bus.req_addr, 32'h8);
    for (int i = 5; i < 8; i++) begin         // C5..C7
      adv();
      smp();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", pc, 32'h4);
      chk("stall_no_req", 32'(bus.req_valid), 32'd0);
    end
    adv();                                   // C8
    stall = 1'b0;
    smp();
    chk("c8_pc", pc, 32'h4);
    adv();                                   // C9
    smp();
    chk("c9_valid", 32'(instr_valid), 32'd1);
    chk("c9_pc", pc, 32'h8);
    chk("c9_instr", instruction, word_of(32'h8));
    chk("c9_req_addr", bus.req_addr, 32'hC);

    // 4: branch to 0x100 while waiting for addr 12
    adv();                                   // C10
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    smp();
    chk("c10_pc_hold", pc, 32'h8);
    chk("c10_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C11
    branch_taken = 1'b0;
    smp();
    chk("c11_valid", 32'(instr_valid), 32'd0);
    chk("c11_req_addr", bus.req_addr, 32'h100);
    adv();                                   // C12
    smp();
    chk("c12_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C13
    bus.req_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0203;
    smp();
    chk("c13_pc", pc, 32'h100);
    chk("c13_instr", instruction, word_of(32'h100));

    // 5 + 2: unaligned target in REQ with ready=0, then ready low 3 cycles
    adv();                                   // C14
    branch_taken = 1'b0;
    smp();
    chk("c14_req_addr", bus.req_addr, 32'h200);
    chk("c14_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C15
    smp();
    chk("c15_req_valid", 32'(bus.req_valid), 32'd1);
    chk("c15_req_addr", bus.req_addr, 32'h200);
    adv();                                   // C16
    bus.req_ready = 1'b1;
    smp();
    chk("c16_req_addr", bus.req_addr, 32'h200);
    adv();                                   // C17
    smp();
    chk("c17_req_valid", 32'(bus.req_valid), 32'd0);
    chk("c17_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C18
    branch_taken = 1'b1;                     // accepted request -> DISCARD
    branch_target = 32'h0000_0300;
    smp();
    chk("c18_pc", pc, 32'h200);
    chk("c18_instr", instruction, word_of(32'h200));
    adv();                                   // C19
    branch_taken = 1'b0;
    smp();
    chk("c19_discard_no_req", 32'(bus.req_valid), 32'd0);
    chk("c19_valid", 32'(instr_valid), 32'd0);
    adv();                                   // C20
    smp();
    chk("c20_req_addr", bus.req_addr, 32'h300);
    adv();                                   // C21
    adv();                                   // C22
    flush = 1'b1;
    stall = 1'b1;
    mem_auto = 1'b0;
    smp();
    chk("c22_pc", pc, 32'h300);
    chk("c22_instr", instruction, word_of(32'h300));

    // 6: flush beats stall; then reset while in WAIT with a late response
    adv();                                   // C23
    flush = 1'b0;
    stall = 1'b0;
    smp();
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_instr", instruction, NOP);
    chk("flush_pc_hold", pc, 32'h300);
    adv();                                   // C24
    rst = 1'b1;
    bus.req_ready = 1'b0;
    smp();
    chk("mid_rst_req_addr", bus.req_addr, 32'h0);
    adv();                                   // C25
    rst = 1'b0;
    force_resp = 1'b1;
    force_data = 32'hDEAD_BEEF;
    smp();
    chk("post_rst_valid", 32'(instr_valid), 32'd0);
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_req_addr", bus.req_addr, 32'h0);
    chk("dut2_req_addr0", bus2.req_addr, 32'hFFFF_FFFC);
    adv();                                   // C26
    force_resp = 1'b0;
    mem_auto = 1'b1;
    bus.req_ready = 1'b1;
    smp();
    chk("late_resp_valid", 32'(instr_valid), 32'd0);
    chk("late_resp_instr", instruction, NOP);
    chk("late_resp_req", 32'(bus.req_valid), 32'd1);
    adv();                                   // C27
    smp();
    chk("dut2_valid", 32'(instr_valid2), 32'd1);
    chk("dut2_pc", pc2, 32'hFFFF_FFFC);
    chk("dut2_instr", instruction2, word_of(32'hFFFF_FFFC));
    chk("dut2_wrap_addr", bus2.req_addr, 32'h0);
    adv();                                   // C28
    smp();
    chk("c28_valid", 32'(instr_valid), 32'd1);
    chk("c28_pc", pc, 32'h0);
    chk("c28_instr", instruction, word_of(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
